// File: rtl/ss_spreader.sv
// ss_spreader: spread-spectrum transmitter feeding the ss correlator.
// Buffers 32-bit data words in a small FIFO and spreads each bit, MSB first,
// with a programmable PN chip code into signed 12-bit chip samples. Each
// burst is framed by a 2-cycle sync pulse followed by 3 quiet cycles.
//
// Ports:
//   clk, reset         rising-edge clock, async active-low reset
//   din/addr/strobe    register write port (one write per strobe cycle)
//   dout               register read data, combinational on addr
//   data/push_data     word enqueue; dropped while full=1 (unless popping)
//   full               FIFO full
//   samp/push_samp     chip sample and its single-cycle valid
//   sync               burst start marker
//   busy               FSM active or FIFO non-empty
//
// Register map: 0 PN_CODE, 1 CODE_LEN, 2 AMP, 3 CTRL(bit0 ENABLE),
//               4 STATUS {state[9:8], count[7:0]} (RO), 5 WORDS_SENT (RO).
module ss_spreader #(
  parameter int FIFO_DEPTH = 4,
  parameter int SAMP_GAP   = 0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] din,
  input  logic [3:0]  addr,
  input  logic        strobe,
  output logic [31:0] dout,
  input  logic [31:0] data,
  input  logic        push_data,
  output logic        full,
  output logic [11:0] samp,
  output logic        push_samp,
  output logic        sync,
  output logic        busy
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int GW = (SAMP_GAP > 0) ? $clog2(SAMP_GAP + 1) : 1;

  typedef enum logic [1:0] {IDLE = 2'd0, SYNC = 2'd1, GAP = 2'd2, SEND = 2'd3} state_t;

  // Per-word configuration; snapshotted at word start so mid-word register
  // writes only affect the following word.
  typedef struct packed {
    logic [31:0] pn;
    logic [5:0]  len;
    logic [10:0] amp;
  } cfg_t;

  cfg_t        cfg, cur;
  logic        enable;
  logic [31:0] words_sent;

  logic [31:0] mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count, cnt_nxt;

  state_t      state;
  logic [2:0]  tcnt;
  logic [31:0] word_sh;
  logic [4:0]  bit_cnt;
  logic [4:0]  cptr;      // chip index into PN, counts L-1 down to 0
  logic [GW-1:0] gcnt;

  logic fifo_ne, fifo_full, emit, word_end, cont, start, pop, push_ok, go_idle;
  logic chip, cur_bit;
  logic [5:0]  cur_len_m1, cfg_len_m1;
  logic [11:0] amp_pos, samp_val;

  // ---------------- control decode ----------------
  always_comb begin
    fifo_ne    = (count != '0);
    fifo_full  = (count == {1'b1, {AW{1'b0}}});
    emit       = (state == SEND) && (gcnt == '0);
    word_end   = emit && (bit_cnt == 5'd31) && (cptr == 5'd0);
    cont       = fifo_ne && enable;
    start      = (state == IDLE) && enable && fifo_ne;
    // Pop at burst start (end of GAP) or on a word's last sample when the
    // next word follows without a fresh sync.
    pop        = ((state == GAP) && (tcnt == 3'd0)) || (word_end && cont);
    push_ok    = push_data && (!fifo_full || pop);
    cnt_nxt    = count + {{AW{1'b0}}, push_ok} - {{AW{1'b0}}, pop};
    go_idle    = ((state == IDLE) && !start) || (word_end && !cont);
    cur_len_m1 = cur.len - 6'd1;
    cfg_len_m1 = cfg.len - 6'd1;
    cur_bit    = word_sh[31];
    chip       = cur.pn[cptr];
    amp_pos    = {1'b0, cur.amp};
    samp_val   = (cur_bit ^ chip) ? (12'd0 - amp_pos) : amp_pos;
  end

  // ---------------- register file ----------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cfg.pn  <= '0;
      cfg.len <= 6'd32;
      cfg.amp <= 11'h100;
      enable  <= 1'b0;
    end else if (strobe) begin
      case (addr)
        4'd0: cfg.pn  <= din;
        4'd1: cfg.len <= ((din[5:0] == 6'd0) || (din[5:0] > 6'd32)) ? 6'd32 : din[5:0];
        4'd2: cfg.amp <= din[10:0];
        4'd3: enable  <= din[0];
        default: ;
      endcase
    end
  end

  always_comb begin
    dout = '0;
    case (addr)
      4'd0: dout = cfg.pn;
      4'd1: dout = {26'd0, cfg.len};
      4'd2: dout = {21'd0, cfg.amp};
      4'd3: dout = {31'd0, enable};
      4'd4: dout = {22'd0, state, 8'(count)};
      4'd5: dout = words_sent;
      default: dout = '0;
    endcase
  end

  // ---------------- FIFO ----------------
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= data;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
      busy   <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop)     rd_ptr <= rd_ptr + 1'b1;
      count <= cnt_nxt;
      full  <= (cnt_nxt == {1'b1, {AW{1'b0}}});
      busy  <= !go_idle || (cnt_nxt != '0);
    end
  end

  // ---------------- burst FSM ----------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      tcnt       <= '0;
      cur        <= '0;
      word_sh    <= '0;
      bit_cnt    <= '0;
      cptr       <= '0;
      gcnt       <= '0;
      samp       <= '0;
      push_samp  <= 1'b0;
      sync       <= 1'b0;
      words_sent <= '0;
    end else begin
      push_samp <= 1'b0;
      case (state)
        IDLE: if (start) begin
          state <= SYNC;
          sync  <= 1'b1;
          tcnt  <= 3'd1;
        end
        SYNC: if (tcnt == 3'd0) begin
          state <= GAP;
          sync  <= 1'b0;
          tcnt  <= 3'd2;
        end else tcnt <= tcnt - 3'd1;
        GAP: if (tcnt == 3'd0) begin
          state <= SEND;
          gcnt  <= '0;
        end else tcnt <= tcnt - 3'd1;
        SEND: if (emit) begin
          push_samp <= 1'b1;
          samp      <= samp_val;
          gcnt      <= GW'(SAMP_GAP);
          if (word_end) begin
            words_sent <= words_sent + 32'd1;
            if (!cont) state <= IDLE;
          end else if (cptr == 5'd0) begin
            word_sh <= word_sh << 1;
            bit_cnt <= bit_cnt + 5'd1;
            cptr    <= cur_len_m1[4:0];
          end else begin
            cptr <= cptr - 5'd1;
          end
        end else begin
          gcnt <= gcnt - 1'b1;
        end
        default: state <= IDLE;
      endcase
      // Word load overrides the per-sample updates above on the pop edge.
      if (pop) begin
        word_sh <= mem[rd_ptr];
        cur     <= cfg;
        bit_cnt <= '0;
        cptr    <= cfg_len_m1[4:0];
      end
    end
  end

endmodule

// File: tb/tb_ss_spreader.sv
module tb_ss_spreader;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] din = '0;
  logic [3:0]  addr = '0;
  logic        strobe = 1'b0;
  logic [31:0] dout;
  logic [31:0] data = '0;
  logic        push_data = 1'b0;
  logic        full;
  logic [11:0] samp;
  logic        push_samp, sync, busy;

  always #5 clk = ~clk;

  ss_spreader #(.FIFO_DEPTH(4), .SAMP_GAP(0)) dut (
    .clk(clk), .reset(reset), .din(din), .addr(addr), .strobe(strobe),
    .dout(dout), .data(data), .push_data(push_data), .full(full),
    .samp(samp), .push_samp(push_samp), .sync(sync), .busy(busy)
  );

  int checks = 0, errors = 0;
  logic [11:0] q[$];
  int cyc = 0, last_cyc = 0, first_cyc = 0, nsync = 0, nsamp = 0;
  logic sync_q = 1'b0, mark_first = 1'b0;
  int s0, n0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic rd(input logic [3:0] a, input logic [31:0] exp, input string tag);
    addr = a;
    #1;
    chk(tag, dout, exp);
  endtask

  task automatic wr(input logic [3:0] a, input logic [31:0] v);
    @(negedge clk);
    addr = a; din = v; strobe = 1'b1;
    @(negedge clk);
    strobe = 1'b0;
  endtask

  task automatic push(input logic [31:0] v);
    @(negedge clk);
    data = v; push_data = 1'b1;
    @(negedge clk);
    push_data = 1'b0;
  endtask

  function automatic logic [11:0] es(input logic b, input logic c, input logic [10:0] a);
    logic [11:0] m;
    m = {1'b0, a};
    if (b == c) return m;
    return ~m + 12'd1;
  endfunction

  // Expected samples for one word: MSB first, chips PN[L-1] .. PN[0].
  task automatic model(input logic [31:0] w, input logic [31:0] pn, input int len, input logic [10:0] a);
    for (int i = 31; i >= 0; i--)
      for (int k = 0; k < len; k++)
        q.push_back(es(w[i], pn[len-1-k], a));
  endtask

  task automatic wait_done(input string tag, input int maxc, input logic need_idle);
    int n;
    n = 0;
    while ((q.size() != 0 || (need_idle && busy !== 1'b0)) && n < maxc) begin
      @(negedge clk);
      n++;
    end
    chk(tag, 32'(n < maxc), 32'd1);
  endtask

  task automatic wait_samp(input string tag, input int base);
    int n;
    n = 0;
    while (nsamp <= base && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk(tag, 32'(n < 100), 32'd1);
  endtask

  // Checks sync framing: 2 high, 3 quiet, first sample 6 cycles after rise.
  task automatic wait_sync(input string tag);
    int n;
    n = 0;
    while (sync !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_seen"}, 32'(sync), 32'd1);
    @(negedge clk);
    chk({tag, "_sync2"}, 32'(sync), 32'd1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk({tag, "_quiet_sync"}, 32'(sync), 32'd0);
      chk({tag, "_quiet_push"}, 32'(push_samp), 32'd0);
    end
    @(negedge clk);
    chk({tag, "_first_push"}, 32'(push_samp), 32'd1);
  endtask

  initial begin
    fork
      begin : mon
        logic [11:0] ev;
        forever begin
          @(negedge clk);
          cyc++;
          if (sync === 1'b1 && sync_q !== 1'b1) nsync++;
          sync_q = sync;
          if (push_samp === 1'b1) begin
            nsamp++;
            last_cyc = cyc;
            if (mark_first) begin first_cyc = cyc; mark_first = 1'b0; end
            checks++;
            assert (q.size() != 0) else begin
              errors++;
              $error("FAIL unexpected_samp: observed %h expected none", samp);
            end
            if (q.size() != 0) begin
              ev = q.pop_front();
              chk("samp", {20'd0, samp}, {20'd0, ev});
            end
          end
        end
      end
    join_none

    // ---- reset state ----
    #1 reset = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_push_samp", 32'(push_samp), 32'd0);
    chk("rst_sync", 32'(sync), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_full", 32'(full), 32'd0);
    chk("rst_samp", 32'(samp), 32'd0);
    rd(4'd0, 32'd0, "rst_pn");
    rd(4'd1, 32'd32, "rst_len");
    rd(4'd2, 32'h100, "rst_amp");
    rd(4'd3, 32'd0, "rst_ctrl");
    rd(4'd4, 32'd0, "rst_status");
    rd(4'd5, 32'd0, "rst_words");
    rd(4'd9, 32'd0, "unused_addr");
    @(negedge clk);
    reset = 1'b1;

    // ---- basic spread ----
    wr(4'd0, 32'hA);
    wr(4'd1, 32'd4);
    wr(4'd5, 32'h1234);          // read-only, ignored
    rd(4'd5, 32'd0, "words_ro");
    model(32'h8000_0000, 32'hA, 4, 11'h100);
    push(32'h8000_0000);
    wr(4'd3, 32'd1);
    wait_sync("basic");
    wait_done("basic_done", 400, 1'b1);
    rd(4'd5, 32'd1, "basic_words");
    rd(4'd4, 32'd0, "basic_status");
    chk("basic_busy", 32'(busy), 32'd0);

    // ---- back-to-back words, CODE_LEN 0 -> 32 ----
    wr(4'd0, 32'd0);
    wr(4'd1, 32'd0);
    rd(4'd1, 32'd32, "len_zero");
    model(32'hFFFF_FFFF, 32'd0, 32, 11'h100);
    model(32'h0000_0000, 32'd0, 32, 11'h100);
    s0 = nsync;
    n0 = nsamp;
    mark_first = 1'b1;
    push(32'hFFFF_FFFF);
    push(32'h0000_0000);
    wait_done("b2b_done", 3000, 1'b1);
    chk("b2b_one_sync", 32'(nsync - s0), 32'd1);
    chk("b2b_nsamp", 32'(nsamp - n0), 32'd2048);
    chk("b2b_contiguous", 32'(last_cyc - first_cyc), 32'd2047);
    rd(4'd5, 32'd3, "b2b_words");

    // ---- FIFO full / drop ----
    wr(4'd3, 32'd0);
    wr(4'd1, 32'd40);
    rd(4'd1, 32'd32, "len_clamp");
    wr(4'd1, 32'd3);
    wr(4'd0, 32'd5);
    for (int i = 0; i < 4; i++) begin
      push(32'h1111_0000 + 32'(i));
      chk("fifo_full_flag", 32'(full), 32'(i == 3));
      model(32'h1111_0000 + 32'(i), 32'd5, 3, 11'h100);
    end
    push(32'hDEAD_BEEF);
    chk("fifo_full_drop", 32'(full), 32'd1);
    rd(4'd4, 32'd4, "fifo_status4");
    s0 = nsync;
    wr(4'd3, 32'd1);
    wait_done("fifo_done", 3000, 1'b1);
    rd(4'd5, 32'd7, "fifo_words");
    chk("fifo_one_sync", 32'(nsync - s0), 32'd1);
    chk("fifo_full_clr", 32'(full), 32'd0);

    // ---- mid-word AMP change ----
    wr(4'd3, 32'd0);
    push(32'h1234_5678);
    push(32'h9ABC_DEF0);
    model(32'h1234_5678, 32'd5, 3, 11'h100);
    model(32'h9ABC_DEF0, 32'd5, 3, 11'h7FF);
    n0 = nsamp;
    wr(4'd3, 32'd1);
    wait_samp("amp_start", n0);
    wr(4'd2, 32'h7FF);
    rd(4'd2, 32'h7FF, "amp_reg");
    wait_done("amp_done", 2000, 1'b1);
    rd(4'd5, 32'd9, "amp_words");

    // ---- ENABLE cleared mid-word ----
    wr(4'd3, 32'd0);
    push(32'hCAFE_F00D);
    push(32'h0F0F_A5A5);
    model(32'hCAFE_F00D, 32'd5, 3, 11'h7FF);
    n0 = nsamp;
    wr(4'd3, 32'd1);
    wait_samp("dis_start", n0);
    wr(4'd3, 32'd0);
    wait_done("dis_word", 1000, 1'b0);
    repeat (3) @(negedge clk);
    chk("dis_busy", 32'(busy), 32'd1);
    chk("dis_push", 32'(push_samp), 32'd0);
    rd(4'd4, 32'd1, "dis_status");
    rd(4'd5, 32'd10, "dis_words");
    model(32'h0F0F_A5A5, 32'd5, 3, 11'h7FF);
    wr(4'd3, 32'd1);
    wait_done("dis_resume", 1000, 1'b1);
    rd(4'd5, 32'd11, "dis_words2");

    // ---- async reset mid-burst ----
    model(32'h5555_AAAA, 32'd5, 3, 11'h7FF);
    n0 = nsamp;
    push(32'h5555_AAAA);
    push(32'h7777_0000);
    wait_samp("ar_start", n0);
    repeat (5) @(negedge clk);
    #2 reset = 1'b0;
    q.delete();
    #1;
    chk("ar_push", 32'(push_samp), 32'd0);
    chk("ar_sync", 32'(sync), 32'd0);
    chk("ar_busy", 32'(busy), 32'd0);
    chk("ar_samp", 32'(samp), 32'd0);
    rd(4'd0, 32'd0, "ar_pn");
    rd(4'd2, 32'h100, "ar_amp");
    rd(4'd4, 32'd0, "ar_status");
    rd(4'd5, 32'd0, "ar_words");
    @(negedge clk);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    chk("ar_flushed_busy", 32'(busy), 32'd0);
    rd(4'd4, 32'd0, "ar_flushed_status");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/ss_spreader.md
Name: ss_spreader

Overview:
Spread-spectrum transmitter that feeds the ss correlator. It accepts 32-bit data words and spreads each bit with a programmable PN chip code. It emits signed 12-bit chip samples on a push_samp/samp interface and frames each burst with a sync pulse, matching what the correlator's sample input expects. It is configured through the same 4-bit addr / 32-bit din / strobe register port as the correlator and is used both as a bench stimulus generator and as on-chip loopback.

Parameters:
FIFO_DEPTH, 4, number of data words buffered (power of 2, >=2)
SAMP_GAP, 0, idle cycles inserted after every push_samp (0 = one sample per clock)

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous, active-low (0 = reset asserted)
din  input  32  register write data
addr  input  4  register address
strobe  input  1  register write enable, one cycle per write
dout  output  32  register read data, combinational on addr
data  input  32  data word to transmit
push_data  input  1  enqueue data when 1 and full==0
full  output  1  FIFO full; push_data ignored while 1
samp  output  12  two's-complement chip sample
push_samp  output  1  samp valid, single-cycle pulse
sync  output  1  burst start marker
busy  output  1  state != IDLE or FIFO non-empty

Behaviour:
- Registers, written on clk when strobe=1 (reset values in brackets): 0 PN_CODE[31:0] [0]; 1 CODE_LEN[5:0] [32], where 0 or >32 is stored as 32; 2 AMP[10:0] [0x100], positive magnitude; 3 CTRL bit0 ENABLE [0]; 4 STATUS, read-only: {state[1:0] in [9:8], fifo count in [7:0]}; 5 WORDS_SENT[31:0] [0], read-only, increments when a word's last sample is pushed, wraps to 0 after 0xFFFFFFFF. Writes to 4/5 and to unused addresses are ignored. Unused addresses read 0.
- All outputs are registered and change only after a clk rising edge. At reset: samp=0, push_samp=0, sync=0, full=0, busy=0, FIFO empty, state=IDLE.
- FIFO: push with full=1 drops the word. Simultaneous push and pop is allowed when full=1; count stays unchanged.
- States:
  - IDLE -> SYNC when ENABLE=1 and FIFO non-empty.
  - SYNC lasts 2 cycles with sync=1, then goes to GAP.
  - GAP lasts 3 cycles with sync=0, then goes to SEND.
  - SEND: at word start, pop the FIFO and snapshot PN_CODE, CODE_LEN and AMP. Register writes during a word take effect at the next word.
- Spreading: bits are sent MSB first. For bit b and chip index k = 0..L-1 (L = CODE_LEN), chip c = PN_CODE[L-1-k]. The sample is +AMP if (b^c)==0, else -AMP, sign-extended to 12 bits. Each word produces 32*L samples.
- Sample rate: one push_samp, then SAMP_GAP cycles with push_samp=0, repeating.
- After a word's last sample: if the FIFO is non-empty and ENABLE=1, start the next word with no sync. Otherwise return to IDLE. The next burst is preceded by a fresh sync.
- The first push_samp of a burst occurs 6 cycles after the IDLE->SYNC transition edge (2 sync + 3 gap + 1).
- ENABLE cleared mid-word: the current word completes, then IDLE. The FIFO is retained.
- Async reset mid-operation: outputs return to reset values immediately, the FIFO is flushed and registers reset.
- samp holds its last value when push_samp=0.

Test Plan:
- Reset: reset=0 at any time -> dout reads PN_CODE=0, CODE_LEN=32, AMP=0x100; push_samp=0, sync=0, busy=0 immediately.
- Basic spread: PN_CODE=0xA, CODE_LEN=4, AMP=0x100, ENABLE=1, push 0x80000000 -> sync high 2 cycles, 3 idle, then 128 consecutive samples 0x100,0xF00,0x100,0xF00 (bit 1), then 0xF00,0x100,0xF00,0x100 repeated for 31 bits; WORDS_SENT=1; busy falls.
- Back-to-back: push 0xFFFFFFFF, 0x00000000 with CODE_LEN=32, PN_CODE=0 -> one sync, 1024 samples of 0xF00 then 1024 of 0x100, no gap between words.
- FIFO full: ENABLE=0, push 5 words with depth 4 -> full=1 after the 4th; the 5th is dropped; STATUS count=4; set ENABLE -> exactly 4 words sent.
- Mid-word reconfiguration: write AMP=0x7FF during word 1 -> word 1 uses the old AMP, word 2 samples are ±0x7FF (0x7FF/0x801).
- Loopback: drive the ss correlator with this block's samp/push_samp/sync, using matching PN -> correlator emits expected corr values from the golden pattern file.
